ram_arbiter: RTL

- Shares the single 4K x 4 program/data RAM between two requesters.
  - Requester 0 is the CPU operand/data path.
  - Requester 1 is an external port (program loader / pushbutton-driven debug monitor).
- Serialises accesses and generates clean setup/strobe/hold timing for the level-sensitive RAM (write happens whenever csRAM and weRAM are both high).
- Sits between the uP top level and the RAM instance. The top level owns the tristate data bus, using ram_drive as its enable.

---
 rtl/ram_arbiter_pkg.sv | 23 ++
 rtl/ram_arb_pick.sv | 43 ++++
 rtl/ram_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_arbiter_pkg : shared encodings and defaults for the RAM arbiter  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package ram_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_STROBE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 4;

   localparam int REQ_CPU = 0;
   localparam int REQ_EXT = 1;

   // Wide enough for STROBE_CYCLES-1 over the legal range 1..4
   localparam int CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_arb_pick : winner selection with round-robin memory (rr_last)    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ram_arb_pick
   import ram_arbiter_pkg::*;
#(
   parameter int CPU_PRIORITY = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       load,
   output logic [1:0] winner
);

   // 1 = external requester won last, so the CPU wins the next tie
   logic rr_last;

   always_ff @(posedge clock) begin
      if (!reset) begin
         rr_last <= 1'b1;
      end else if (load) begin
         rr_last <= winner[REQ_EXT];
      end
   end

   always_comb begin
      winner = 2'b00;
      if (req[REQ_CPU] && req[REQ_EXT]) begin
         if ((CPU_PRIORITY != 0) || rr_last) begin
            winner[REQ_CPU] = 1'b1;
         end else begin
            winner[REQ_EXT] = 1'b1;
         end
      end else begin
         winner = req;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_arbiter : two-requester arbiter for a level-sensitive 4Kx4 RAM   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int STROBE_CYCLES = 1,
   parameter int CPU_PRIORITY  = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_drive,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [CNT_W-1:0] cnt;
   logic             lat_we;
   logic [1:0]       winner;
   logic             load;
   logic             cs_nxt;
   logic             we_nxt;
   logic [1:0]       ack_nxt;

   assign load      = (state == ST_IDLE) && (|req);
   assign ram_drive = ram_cs & ram_we;

   ram_arb_pick #(
      .CPU_PRIORITY(CPU_PRIORITY)
   ) u_pick (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .load  (load),
      .winner(winner)
   );

   // State register plus datapath/output registers; strobe outputs are
   // registered so csRAM/weRAM edges are glitch-free.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         gnt       <= 2'b00;
         ack       <= 2'b00;
         ram_cs    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         rdata     <= '0;
      end else begin
         state  <= next_state;
         ram_cs <= cs_nxt;
         ram_we <= we_nxt;
         ack    <= ack_nxt;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  gnt       <= winner;
                  ram_addr  <= winner[REQ_EXT] ? addr1  : addr0;
                  ram_wdata <= winner[REQ_EXT] ? wdata1 : wdata0;
                  lat_we    <= winner[REQ_EXT] ? we[REQ_EXT] : we[REQ_CPU];
               end
            end
            ST_SETUP: begin
               cnt <= CNT_W'(STROBE_CYCLES - 1);
            end
            ST_STROBE: begin
               if (cnt == '0) begin
                  if (!lat_we) begin
                     rdata <= ram_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               gnt <= 2'b00;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (|req) next_state = ST_SETUP;
         ST_SETUP:  next_state = ST_STROBE;
         ST_STROBE: if (cnt == '0) next_state = ST_DONE;
         ST_DONE:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      cs_nxt  = (next_state == ST_STROBE);
      we_nxt  = cs_nxt & lat_we;
      ack_nxt = (next_state == ST_DONE) ? gnt : 2'b00;
   end

endmodule
`default_nettype wire
